// File: rtl/ws2811_pkg.sv
// Shared WS2811 definitions: bit timing at the 20 MHz pixel clock, receiver
// state encoding and the wire-order (G,R,B) <-> host-order (R,G,B) reorder.
package ws2811_pkg;

  localparam int unsigned CLK_HZ     = 20_000_000;
  // Nominal transmitter bit timing in clk cycles (0: 5 high / 21 low, 1: 20 high / 6 low).
  localparam int unsigned T0H_CLKS   = 5;
  localparam int unsigned T0L_CLKS   = 21;
  localparam int unsigned T1H_CLKS   = 20;
  localparam int unsigned T1L_CLKS   = 6;
  localparam int unsigned TBIT_CLKS  = 26;
  // 50 us of low marks a latch/reset between frames.
  localparam int unsigned RESET_NOM_CLKS = 1000;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_e;

  // Wire order {G,R,B} to host order {R,G,B}.
  function automatic logic [23:0] grb_to_rgb(input logic [23:0] grb);
    return {grb[15:8], grb[23:16], grb[7:0]};
  endfunction

  // Host order {R,G,B} to wire order {G,R,B}.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2811_pulse_meter.sv
// Input conditioning for the WS2811 receiver: 2-flop synchroniser, one
// edge-detect flop, and width counters for the current high and low pulse.
// Edges reach rise_o/fall_o two clocks after the pin and are acted on by the
// consumer at the third clock edge.
module ws2811_pulse_meter #(
  parameter int unsigned RESET_CLKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_i,
  output logic       rise_o,
  output logic       fall_o,
  output logic [7:0] hcnt_o,
  output logic       latch_o
);

  localparam logic [9:0] LCNT_MAX = 10'(RESET_CLKS);

  // sync_q[1] is the synchronised level din_s, sync_q[2] its previous value.
  logic [2:0] sync_q;
  logic [7:0] hcnt_q;
  logic [9:0] lcnt_q;
  logic       din_s;

  assign din_s   = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];
  assign hcnt_o  = hcnt_q;
  assign latch_o = (lcnt_q == LCNT_MAX);

  // Shift the asynchronous pin through the synchroniser and edge-detect flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= {sync_q[1:0], din_i};
  end

  // High width: restarts at the rising edge counting that first high cycle,
  // so at the falling edge hcnt equals the pulse width; saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      hcnt_q <= 8'd0;
    else if (rise_o)                 hcnt_q <= 8'd1;
    else if (din_s && hcnt_q != 8'hFF) hcnt_q <= hcnt_q + 8'd1;
  end

  // Low width: any high level clears it; saturates at the latch length so a
  // sustained low keeps latch_o asserted without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 lcnt_q <= 10'd0;
    else if (din_s)             lcnt_q <= 10'd0;
    else if (lcnt_q != LCNT_MAX) lcnt_q <= lcnt_q + 10'd1;
  end

endmodule

// File: rtl/ws2811_rx.sv
// WS2811 single-wire receiver. Classifies each high pulse as 0/1 (or error),
// assembles 24-bit G,R,B words MSB first, emits them as {R,G,B} with a pixel
// index, and reports each frame at the latch low period.
// Output handshake: pix_valid_o, frame_done_o and bit_err_o are one-cycle
// strobes with no ready/backpressure; pix_index_o/pix_data_o are valid with
// pix_valid_o, frame_pixels_o/frame_err_o with frame_done_o, and all hold
// their last value otherwise. The consumer must accept every strobe.
module ws2811_rx
  import ws2811_pkg::*;
#(
  parameter int unsigned BIT_THRESH = 12,
  parameter int unsigned MIN_HIGH   = 2,
  parameter int unsigned MAX_HIGH   = 40,
  parameter int unsigned RESET_CLKS = 1000,
  parameter int unsigned MAX_PIXELS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_i,
  output logic        pix_valid_o,
  output logic [7:0]  pix_index_o,
  output logic [23:0] pix_data_o,
  output logic        frame_done_o,
  output logic [8:0]  frame_pixels_o,
  output logic        frame_err_o,
  output logic        bit_err_o,
  output logic        synced_o,
  output rx_state_e   state_o
);

  localparam logic [7:0] THRESH_C  = 8'(BIT_THRESH);
  localparam logic [7:0] MIN_H_C   = 8'(MIN_HIGH);
  localparam logic [7:0] MAX_H_C   = 8'(MAX_HIGH);
  localparam logic [8:0] MAX_PIX_C = 9'(MAX_PIXELS);

  logic       rise, fall, latch;
  logic [7:0] hcnt;

  ws2811_pulse_meter #(.RESET_CLKS(RESET_CLKS)) u_meter (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (din_i),
    .rise_o  (rise),
    .fall_o  (fall),
    .hcnt_o  (hcnt),
    .latch_o (latch)
  );

  rx_state_e   state_q;
  logic        synced_q, bad_q, ovf_q;
  logic [23:0] sh_q;
  logic [4:0]  bitcnt_q;
  logic [8:0]  wcnt_q;
  logic        pix_valid_q, frame_done_q, frame_err_q, bit_err_q;
  logic [7:0]  pix_index_q;
  logic [23:0] pix_data_q;
  logic [8:0]  frame_pixels_q;

  logic        pulse_bad, bit_d;
  logic [23:0] sh_d;

  // Classify the just-finished high pulse and form the shifter's next value.
  always_comb begin
    pulse_bad = (hcnt < MIN_H_C) || (hcnt > MAX_H_C);
    bit_d     = (hcnt >= THRESH_C);
    sh_d      = {sh_q[22:0], bit_d};
  end

  // Receiver FSM with bit/word assembly and frame bookkeeping; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SYNC;
      synced_q       <= 1'b0;
      bad_q          <= 1'b0;
      ovf_q          <= 1'b0;
      sh_q           <= '0;
      bitcnt_q       <= '0;
      wcnt_q         <= '0;
      pix_valid_q    <= 1'b0;
      pix_index_q    <= '0;
      pix_data_q     <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      frame_err_q    <= 1'b0;
      bit_err_q      <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      bit_err_q    <= 1'b0;
      case (state_q)
        // Wait for a full latch period so we never start mid-word.
        SYNC: begin
          if (latch) begin
            synced_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        IDLE: begin
          if (rise) state_q <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            state_q <= LOW;
            if (pulse_bad) begin
              bit_err_q <= 1'b1;
              bad_q     <= 1'b1;
            end else if (bitcnt_q == 5'd23) begin
              bitcnt_q <= '0;
              if (wcnt_q == MAX_PIX_C) begin
                ovf_q <= 1'b1;
              end else begin
                pix_valid_q <= 1'b1;
                pix_index_q <= wcnt_q[7:0];
                pix_data_q  <= grb_to_rgb(sh_d);
                wcnt_q      <= wcnt_q + 9'd1;
              end
            end else begin
              sh_q     <= sh_d;
              bitcnt_q <= bitcnt_q + 5'd1;
            end
          end
        end
        // LOW is only reachable after an edge, so a latch here always ends a real frame.
        LOW: begin
          if (rise) begin
            state_q <= HIGH;
          end else if (latch) begin
            frame_done_q   <= 1'b1;
            frame_pixels_q <= wcnt_q;
            frame_err_q    <= bad_q | ovf_q | (bitcnt_q != 5'd0);
            wcnt_q         <= '0;
            bitcnt_q       <= '0;
            bad_q          <= 1'b0;
            ovf_q          <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign pix_valid_o    = pix_valid_q;
  assign pix_index_o    = pix_index_q;
  assign pix_data_o     = pix_data_q;
  assign frame_done_o   = frame_done_q;
  assign frame_pixels_o = frame_pixels_q;
  assign frame_err_o    = frame_err_q;
  assign bit_err_o      = bit_err_q;
  assign synced_o       = synced_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ws2811_rx.sv
// Bench for ws2811_rx: drives WS2811 waveforms on din_i, predicts words and
// frame results from the line protocol, and checks them in a monitor.
`timescale 1ns/1ps
module tb_ws2811_rx;
  import ws2811_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_i = 1'b1;
  logic        pix_valid_o;
  logic [7:0]  pix_index_o;
  logic [23:0] pix_data_o;
  logic        frame_done_o;
  logic [8:0]  frame_pixels_o;
  logic        frame_err_o;
  logic        bit_err_o;
  logic        synced_o;
  rx_state_e   state_o;

  always #25 clk = ~clk;

  ws2811_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .din_i          (din_i),
    .pix_valid_o    (pix_valid_o),
    .pix_index_o    (pix_index_o),
    .pix_data_o     (pix_data_o),
    .frame_done_o   (frame_done_o),
    .frame_pixels_o (frame_pixels_o),
    .frame_err_o    (frame_err_o),
    .bit_err_o      (bit_err_o),
    .synced_o       (synced_o),
    .state_o        (state_o)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];   // {pix_index, R, G, B}
  logic [9:0]  frm_q[$];   // {frame_err, frame_pixels}
  int n_chk = 0;
  int n_pass = 0;
  int exp_bit_err = 0;
  int got_bit_err = 0;

  // Frame-level reference model.
  int m_words = 0;
  bit m_bad = 0, m_ovf = 0, m_part = 0, m_edge = 0;

  // Bit timing used by the driver.
  bit rand_t = 0;
  int t0h = 5, t0l = 21, t1h = 20, t1l = 6;

  logic [23:0] led_ram [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input int hi, input int lo);
    din_i = 1'b1;
    repeat (hi) @(negedge clk);
    din_i = 1'b0;
    repeat (lo) @(negedge clk);
    m_edge = 1;
  endtask

  task automatic send_bit(input bit b);
    int hi, lo;
    if (rand_t) begin
      hi = b ? int'($urandom_range(16, 38)) : int'($urandom_range(3, 8));
      lo = int'($urandom_range(2, 20));
    end else begin
      hi = b ? t1h : t0h;
      lo = b ? t1l : t0l;
    end
    pulse(hi, lo);
  endtask

  // Whole pixel on a word boundary; expectation is queued before the bits go out.
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [23:0] w;
    w = {g, r, b};
    if (m_words < 256) begin
      exp_q.push_back({8'(m_words), r, g, b});
      m_words++;
    end else begin
      m_ovf = 1;
    end
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    if (n % 24 != 0) m_part = 1;
  endtask

  task automatic send_bad_pulse(input int hi);
    m_bad = 1;
    exp_bit_err++;
    pulse(hi, 4);
  endtask

  task automatic model_clear();
    m_words = 0;
    m_bad = 0;
    m_ovf = 0;
    m_part = 0;
    m_edge = 0;
  endtask

  task automatic send_latch();
    if (m_edge) frm_q.push_back({m_bad | m_ovf | m_part, 9'(m_words)});
    din_i = 1'b0;
    repeat (RESET_NOM_CLKS + 20) @(negedge clk);
    model_clear();
  endtask

  task automatic wait_synced(input int budget);
    for (int i = 0; i < budget && !synced_o; i++) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic [31:0] e_pix;
  logic [9:0]  e_frm;

  // Pop and compare whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid_o) begin
        chk("pix_frame_overlap", 32'(frame_done_o), 32'd0);
        if (exp_q.size() == 0) begin
          chk("pix_unexpected", 32'(pix_valid_o), 32'd0);
        end else begin
          e_pix = exp_q.pop_front();
          chk("pix_index", 32'(pix_index_o), 32'(e_pix[31:24]));
          chk("pix_data", 32'(pix_data_o), 32'(e_pix[23:0]));
        end
      end
      if (frame_done_o) begin
        if (frm_q.size() == 0) begin
          chk("frame_unexpected", 32'(frame_done_o), 32'd0);
        end else begin
          e_frm = frm_q.pop_front();
          chk("frame_pixels", 32'(frame_pixels_o), 32'(e_frm[8:0]));
          chk("frame_err", 32'(frame_err_o), 32'(e_frm[9]));
        end
      end
      if (bit_err_o) got_bit_err++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    din_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
    chk("rst_frame_done", 32'(frame_done_o), 32'd0);
    chk("rst_synced", 32'(synced_o), 32'd0);
    chk("rst_bit_err", 32'(bit_err_o), 32'd0);
    chk("rst_pix_data", 32'(pix_data_o), 32'd0);
    chk("rst_frame_pixels", 32'(frame_pixels_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'(SYNC));

    // Released mid-"stream" with din high, then the first latch period.
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    din_i = 1'b0;
    repeat (990) @(negedge clk);
    chk("synced_early", 32'(synced_o), 32'd0);
    wait_synced(60);
    chk("synced", 32'(synced_o), 32'd1);
    repeat (5) @(negedge clk);
    chk("state_idle", 32'(state_o), 32'(IDLE));

    // Single word at nominal timing: wire G=00,R=FF,B=00 -> 0xFF0000.
    t0h = T0H_CLKS; t0l = T0L_CLKS; t1h = T1H_CLKS; t1l = T1L_CLKS;
    send_pixel(8'hFF, 8'h00, 8'h00);
    send_latch();
    // Sustained low after a latch must not repeat frame_done.
    repeat (300) @(negedge clk);

    // Random frames with randomised pulse widths.
    rand_t = 1;
    for (int f = 0; f < 2; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int p = 0; p < n; p++)
        send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
      send_latch();
    end

    // Overflow: 259 incrementing words, fast fixed timing.
    rand_t = 0;
    t0h = 3; t0l = 2; t1h = 14; t1l = 2;
    for (int p = 0; p < 259; p++) send_pixel(8'h00, 8'h00, 8'(p));
    send_latch();

    // Glitch inside the third word, then latch.
    rand_t = 1;
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    send_bits(10);
    send_bad_pulse(1);
    send_latch();

    // Overlong and stuck-high pulses are discarded without shifting word alignment.
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    send_bad_pulse(60);
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    send_bad_pulse(300);
    send_latch();

    // Partial word only.
    send_bits(12);
    send_latch();

    // Loopback: a 10-LED transmitter at nominal timing from a RAM image.
    rand_t = 0;
    t0h = T0H_CLKS; t0l = T0L_CLKS; t1h = T1H_CLKS; t1l = T1L_CLKS;
    for (int i = 0; i < 10; i++) led_ram[i] = 24'($urandom);
    for (int i = 0; i < 10; i++)
      send_pixel(led_ram[i][23:16], led_ram[i][15:8], led_ram[i][7:0]);
    send_latch();

    // Reset mid-frame: truncated frame is dropped, receiver resyncs.
    rand_t = 1;
    send_bits(5);
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("midrst_synced", 32'(synced_o), 32'd0);
    chk("midrst_state", 32'(state_o), 32'(SYNC));
    din_i = 1'b0;
    rst_n = 1'b1;
    wait_synced(1100);
    chk("resynced", 32'(synced_o), 32'd1);
    repeat (20) @(negedge clk);

    chk("pix_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_queue_drained", 32'(frm_q.size()), 32'd0);
    chk("bit_err_count", 32'(got_bit_err), 32'(exp_bit_err));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
